// File: rtl/apb_modport_if.sv
// Command-side interface of the APB subsystem: transfer request, read/write
// select, addresses, write data and the last completed read data.
interface apb_modport_if #(
    parameter int ADDR_WIDTH = 9,
    parameter int DATA_WIDTH = 8
);
    logic                  transfer;
    logic                  READ_WRITE;
    logic [ADDR_WIDTH-1:0] apb_write_paddr;
    logic [ADDR_WIDTH-1:0] apb_read_paddr;
    logic [DATA_WIDTH-1:0] apb_write_data;
    logic [DATA_WIDTH-1:0] apb_read_data_out;

    modport master (
        output transfer,
        output READ_WRITE,
        output apb_write_paddr,
        output apb_read_paddr,
        output apb_write_data,
        input  apb_read_data_out
    );

    modport slave (
        input  transfer,
        input  READ_WRITE,
        input  apb_write_paddr,
        input  apb_read_paddr,
        input  apb_write_data,
        output apb_read_data_out
    );
endinterface

// File: rtl/apb_modport.sv
// APB subsystem: one command-driven APB master bridge and two APB slave
// memories; the address MSB picks the slave, the low bits the location.

// state  | meaning
// IDLE   | no transfer in flight, waiting for transfer
// SETUP  | PSEL asserted, PENABLE low, command latched
// ACCESS | PENABLE high, completes when the selected slave gives PREADY
module apb_modport_master #(
    parameter int ADDR_WIDTH = 9,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  pclk,
    input  logic                  presetn,
    input  logic                  transfer_i,
    input  logic                  read_write_i,
    input  logic [ADDR_WIDTH-1:0] write_paddr_i,
    input  logic [ADDR_WIDTH-1:0] read_paddr_i,
    input  logic [DATA_WIDTH-1:0] write_data_i,
    output logic [DATA_WIDTH-1:0] read_data_o,
    output logic                  psel1_o,
    output logic                  psel2_o,
    output logic                  penable_o,
    output logic                  pwrite_o,
    output logic [ADDR_WIDTH-1:0] paddr_o,
    output logic [DATA_WIDTH-1:0] pwdata_o,
    input  logic [DATA_WIDTH-1:0] prdata_i,
    input  logic                  pready_i
);
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2
    } state_e;

    state_e                state_q, state_d;
    logic                  pwrite_q, pwrite_d;
    logic [ADDR_WIDTH-1:0] paddr_q, paddr_d;
    logic [DATA_WIDTH-1:0] pwdata_q, pwdata_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                  access_done;
    logic                  launch;

    always_ff @(posedge pclk) begin
        if (!presetn) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (transfer_i) state_d = ST_SETUP;
            ST_SETUP:  state_d = ST_ACCESS;
            ST_ACCESS: if (pready_i) state_d = transfer_i ? ST_SETUP : ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        psel1_o   = 1'b0;
        psel2_o   = 1'b0;
        penable_o = 1'b0;
        if (state_q != ST_IDLE) begin
            psel1_o = ~paddr_q[ADDR_WIDTH-1];
            psel2_o = paddr_q[ADDR_WIDTH-1];
        end
        if (state_q == ST_ACCESS) begin
            penable_o = 1'b1;
        end
    end

    // A new command is captured on entry to SETUP, including back-to-back
    // from a completing ACCESS, so later input changes cannot disturb it.
    assign access_done = (state_q == ST_ACCESS) && pready_i;
    assign launch      = transfer_i && ((state_q == ST_IDLE) || access_done);

    always_comb begin
        pwrite_d = pwrite_q;
        paddr_d  = paddr_q;
        pwdata_d = pwdata_q;
        rdata_d  = rdata_q;
        if (access_done && !pwrite_q) begin
            rdata_d = prdata_i;
        end
        if (launch) begin
            pwrite_d = ~read_write_i;
            paddr_d  = read_write_i ? read_paddr_i : write_paddr_i;
            pwdata_d = write_data_i;
        end
    end

    always_ff @(posedge pclk) begin
        if (!presetn) begin
            pwrite_q <= 1'b0;
            paddr_q  <= '0;
            pwdata_q <= '0;
            rdata_q  <= '0;
        end else begin
            pwrite_q <= pwrite_d;
            paddr_q  <= paddr_d;
            pwdata_q <= pwdata_d;
            rdata_q  <= rdata_d;
        end
    end

    assign pwrite_o    = pwrite_q;
    assign paddr_o     = paddr_q;
    assign pwdata_o    = pwdata_q;
    assign read_data_o = rdata_q;
endmodule

module apb_modport_mem #(
    parameter int OFF_WIDTH  = 8,
    parameter int DATA_WIDTH = 8,
    parameter int MEM_DEPTH  = 256
) (
    input  logic                  pclk,
    input  logic                  presetn,
    input  logic                  psel_i,
    input  logic                  penable_i,
    input  logic                  pwrite_i,
    input  logic [OFF_WIDTH-1:0]  paddr_i,
    input  logic [DATA_WIDTH-1:0] pwdata_i,
    output logic [DATA_WIDTH-1:0] prdata_o,
    output logic                  pready_o
);
    logic [DATA_WIDTH-1:0] mem_q [MEM_DEPTH];
    logic                  wr_en;

    assign wr_en    = psel_i && penable_i && pwrite_i;
    assign prdata_o = mem_q[paddr_i];
    assign pready_o = 1'b1;

    always_ff @(posedge pclk) begin
        if (!presetn) begin
            for (int i = 0; i < MEM_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (wr_en) begin
            mem_q[paddr_i] <= pwdata_i;
        end
    end
endmodule

module apb_modport #(
    parameter int ADDR_WIDTH = 9,
    parameter int DATA_WIDTH = 8,
    parameter int MEM_DEPTH  = 256
) (
    input  logic          pclk,
    input  logic          presetn,
    apb_modport_if.slave  cmd
);
    localparam int OFF_WIDTH = ADDR_WIDTH - 1;

    logic                  psel1, psel2, penable, pwrite;
    logic [ADDR_WIDTH-1:0] paddr;
    logic [DATA_WIDTH-1:0] pwdata;
    logic [DATA_WIDTH-1:0] prdata1, prdata2, prdata;
    logic                  pready1, pready2, pready;

    apb_modport_master #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_master (
        .pclk          (pclk),
        .presetn       (presetn),
        .transfer_i    (cmd.transfer),
        .read_write_i  (cmd.READ_WRITE),
        .write_paddr_i (cmd.apb_write_paddr),
        .read_paddr_i  (cmd.apb_read_paddr),
        .write_data_i  (cmd.apb_write_data),
        .read_data_o   (cmd.apb_read_data_out),
        .psel1_o       (psel1),
        .psel2_o       (psel2),
        .penable_o     (penable),
        .pwrite_o      (pwrite),
        .paddr_o       (paddr),
        .pwdata_o      (pwdata),
        .prdata_i      (prdata),
        .pready_i      (pready)
    );

    apb_modport_mem #(
        .OFF_WIDTH  (OFF_WIDTH),
        .DATA_WIDTH (DATA_WIDTH),
        .MEM_DEPTH  (MEM_DEPTH)
    ) u_slave1 (
        .pclk      (pclk),
        .presetn   (presetn),
        .psel_i    (psel1),
        .penable_i (penable),
        .pwrite_i  (pwrite),
        .paddr_i   (paddr[OFF_WIDTH-1:0]),
        .pwdata_i  (pwdata),
        .prdata_o  (prdata1),
        .pready_o  (pready1)
    );

    apb_modport_mem #(
        .OFF_WIDTH  (OFF_WIDTH),
        .DATA_WIDTH (DATA_WIDTH),
        .MEM_DEPTH  (MEM_DEPTH)
    ) u_slave2 (
        .pclk      (pclk),
        .presetn   (presetn),
        .psel_i    (psel2),
        .penable_i (penable),
        .pwrite_i  (pwrite),
        .paddr_i   (paddr[OFF_WIDTH-1:0]),
        .pwdata_i  (pwdata),
        .prdata_o  (prdata2),
        .pready_o  (pready2)
    );

    // The unselected slave's response is never looked at.
    assign prdata = psel2 ? prdata2 : prdata1;
    assign pready = psel2 ? pready2 : pready1;
endmodule

// File: tb/tb_apb_modport.sv
// Bench for apb_modport: directed plan plus random traffic, checked every
// cycle against a flat 512-byte memory model with a two-edge completion delay.
module tb_apb_modport;
    logic pclk    = 1'b0;
    logic presetn = 1'b0;

    apb_modport_if bus ();

    apb_modport dut (
        .pclk    (pclk),
        .presetn (presetn),
        .cmd     (bus)
    );

    always #5 pclk = ~pclk;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    logic [7:0] mdl_mem [512];
    logic [7:0] mdl_rdata = 8'h00;
    int         mdl_left  = 0;   // edges until the in-flight command completes
    bit         mdl_rd    = 1'b0;
    logic [8:0] mdl_addr  = '0;
    logic [7:0] mdl_wdata = '0;
    bit         mdl_free  = 1'b0;

    always @(posedge pclk) begin
        if (!presetn) begin
            for (int i = 0; i < 512; i++) mdl_mem[i] = 8'h00;
            mdl_rdata = 8'h00;
            mdl_left  = 0;
        end else begin
            mdl_free = (mdl_left <= 1);
            if (mdl_left == 1) begin
                if (mdl_rd) mdl_rdata = mdl_mem[mdl_addr];
                else        mdl_mem[mdl_addr] = mdl_wdata;
            end
            if (mdl_left > 0) mdl_left--;
            if (mdl_free && bus.transfer) begin
                mdl_rd    = bus.READ_WRITE;
                mdl_addr  = bus.READ_WRITE ? bus.apb_read_paddr : bus.apb_write_paddr;
                mdl_wdata = bus.apb_write_data;
                mdl_left  = 2;
            end
        end
    end

    always @(negedge pclk) begin
        if (chk_en) begin
            checks++;
            if (bus.apb_read_data_out !== mdl_rdata) begin
                errors++;
                $display("FAIL cycle_compare t=%0t read_data_out got=%02h expected=%02h",
                         $time, bus.apb_read_data_out, mdl_rdata);
            end
        end
    end

    task automatic check(input string name, input logic [7:0] exp);
        checks++;
        if (bus.apb_read_data_out !== exp) begin
            errors++;
            $display("FAIL %s got=%02h expected=%02h", name, bus.apb_read_data_out, exp);
        end
    endtask

    task automatic scramble();
        bus.READ_WRITE      = 1'($urandom);
        bus.apb_write_paddr = 9'($urandom);
        bus.apb_read_paddr  = 9'($urandom);
        bus.apb_write_data  = 8'($urandom);
    endtask

    task automatic drive(input bit rd, input logic [8:0] addr, input logic [7:0] data);
        scramble();
        bus.transfer   = 1'b1;
        bus.READ_WRITE = rd;
        if (rd) bus.apb_read_paddr  = addr;
        else    bus.apb_write_paddr = addr;
        bus.apb_write_data = data;
    endtask

    // One isolated command; returns at the negedge after its completing edge.
    task automatic single(input bit rd, input logic [8:0] addr, input logic [7:0] data);
        @(negedge pclk);
        drive(rd, addr, data);
        @(negedge pclk);
        bus.transfer = 1'b0;
        scramble();
        @(negedge pclk);
        @(negedge pclk);
    endtask

    initial begin
        bus.transfer        = 1'b0;
        bus.READ_WRITE      = 1'b0;
        bus.apb_write_paddr = '0;
        bus.apb_read_paddr  = '0;
        bus.apb_write_data  = '0;

        // reset
        presetn = 1'b0;
        @(negedge pclk);
        @(negedge pclk);
        chk_en = 1'b1;
        check("reset_value", 8'h00);
        presetn = 1'b1;

        single(1'b1, 9'h000, 8'h00);
        check("read_000_after_reset", 8'h00);
        single(1'b1, 9'h1FF, 8'h00);
        check("read_1ff_after_reset", 8'h00);

        // slave 1 write/read, slave isolation
        single(1'b0, 9'h005, 8'hA5);
        single(1'b1, 9'h005, 8'h00);
        check("read_005", 8'hA5);
        single(1'b0, 9'h105, 8'h3C);
        single(1'b1, 9'h105, 8'h00);
        check("read_105", 8'h3C);
        single(1'b1, 9'h005, 8'h00);
        check("read_005_isolated", 8'hA5);

        // hold through a write and idle time
        single(1'b0, 9'h050, 8'h99);
        repeat (5) @(negedge pclk);
        check("hold_after_write_idle", 8'hA5);

        // back-to-back: each command held for its two cycles with transfer=1
        @(negedge pclk);
        drive(1'b0, 9'h0FF, 8'h11); @(negedge pclk); @(negedge pclk);
        drive(1'b0, 9'h1FF, 8'h22); @(negedge pclk); @(negedge pclk);
        drive(1'b1, 9'h0FF, 8'h00); @(negedge pclk); @(negedge pclk);
        drive(1'b1, 9'h1FF, 8'h00); @(negedge pclk); @(negedge pclk);
        check("b2b_read_0ff", 8'h11);
        bus.transfer = 1'b0;
        @(negedge pclk);
        @(negedge pclk);
        check("b2b_read_1ff", 8'h22);

        // reset while in SETUP of a write
        @(negedge pclk);
        drive(1'b0, 9'h010, 8'h77);
        @(negedge pclk);
        presetn      = 1'b0;
        bus.transfer = 1'b0;
        @(negedge pclk);
        presetn = 1'b1;
        check("rdata_after_mid_reset", 8'h00);
        single(1'b1, 9'h010, 8'h00);
        check("read_010_after_abort", 8'h00);

        // random traffic on a small address set so reads hit earlier writes
        repeat (600) begin
            @(negedge pclk);
            scramble();
            bus.transfer       = ($urandom_range(0, 3) != 0);
            bus.apb_write_paddr = {1'($urandom), 4'h0, 4'($urandom)};
            bus.apb_read_paddr  = {1'($urandom), 4'h0, 4'($urandom)};
            presetn = ($urandom_range(0, 99) != 0);
        end
        @(negedge pclk);
        presetn      = 1'b1;
        bus.transfer = 1'b0;
        repeat (4) @(negedge pclk);

        chk_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/apb_modport.md
Name: apb_modport

Overview:
- Self-contained APB subsystem: one APB master bridge plus two 256x8 APB slave memories.
- Driven by a simple transfer/command request interface; returns read data on apb_read_data_out.
- Address bit 8 selects the slave; bits 7:0 address a location inside the selected slave.
- Sits behind the driver/monitor clocking-block interface as the complete design under test.

Parameters:
- ADDR_WIDTH, 9, external address width; MSB is the slave select.
- DATA_WIDTH, 8, data width.
- MEM_DEPTH, 256, locations per slave (2^(ADDR_WIDTH-1)).

Ports:
- pclk  input  1  clock; all logic on the rising edge.
- presetn  input  1  reset; synchronous, active-low.
- transfer  input  1  request a transaction; sampled in IDLE and in ACCESS.
- READ_WRITE  input  1  1 = read, 0 = write.
- apb_write_paddr  input  9  write address; [8] slave select, [7:0] offset.
- apb_read_paddr  input  9  read address; same encoding.
- apb_write_data  input  8  write data.
- apb_read_data_out  output  8  last completed read data.

Behaviour:
- Reset, when presetn is 0 at a rising edge:
  - master FSM goes to IDLE; internal PSEL1, PSEL2, PENABLE and PWRITE go to 0; latched address and data go to 0.
  - apb_read_data_out goes to 0x00.
  - both slave memories are cleared to 0x00.
  - reset takes effect even mid-transaction; the aborted transfer has no effect on memory.
- Master FSM states: IDLE, SETUP, ACCESS.
- IDLE:
  - transfer=1 goes to SETUP; otherwise stay in IDLE.
  - On entry to SETUP, latch:
    - PWRITE = ~READ_WRITE;
    - PADDR = apb_read_paddr if READ_WRITE=1, else apb_write_paddr;
    - PWDATA = apb_write_data.
- SETUP:
  - PSEL1 = ~PADDR[8], PSEL2 = PADDR[8], PENABLE = 0.
  - Always goes to ACCESS on the next edge.
- ACCESS:
  - PENABLE = 1, PSEL held; slaves assert PREADY=1 (zero wait states), so ACCESS lasts exactly one cycle.
  - Write: the selected slave stores PWDATA at PADDR[7:0] on the closing edge.
  - Read: the selected slave drives PRDATA = mem[PADDR[7:0]] combinationally; the master captures it into apb_read_data_out on the closing edge.
  - Next state: if transfer=1, go to SETUP and latch the new command (back-to-back, no IDLE cycle); otherwise go to IDLE.
- Timing:
  - transfer sampled high at edge N enters SETUP; edge N+1 enters ACCESS.
  - The transaction completes at edge N+2; read data is visible after edge N+2.
  - Throughput is one transaction per 2 cycles.
- apb_read_data_out holds its value through writes and idle periods; it changes only on a completed read or on reset.
- Command inputs changing during SETUP/ACCESS do not affect the in-flight transaction (latched values are used).
- The unselected slave never writes and its PRDATA is ignored (mux on PSEL).
- No error response: every address is valid. Widths are exact; no arithmetic wrap is involved.

Test Plan:
- Reset: hold presetn=0 for 2 edges, then read 0x000 and 0x1FF -> apb_read_data_out = 0x00 at reset and after each read.
- Slave-1 write/read: write addr 0x005 data 0xA5, then read 0x005 -> 0xA5, valid 2 edges after the read request is sampled.
- Slave isolation: write 0x105=0x3C, then read 0x105 -> 0x3C and read 0x005 -> 0xA5 (slave 1 untouched).
- Back-to-back: hold transfer=1 with the commands write 0x0FF=0x11, write 0x1FF=0x22, read 0x0FF, read 0x1FF -> reads return 0x11 then 0x22, with no IDLE cycle between transactions.
- Reset mid-operation: issue write 0x010=0x77 and deassert presetn during SETUP; after release, read 0x010 -> 0x00.
- Hold behaviour: after reading 0xA5, perform a write and idle 5 cycles -> apb_read_data_out stays 0xA5.
